// File: rtl/burst_ram.sv
// Burst RAM responder: single-port memory that serves fixed-length read and
// write bursts after an initialisation period, emulating external DRAM timing.
module burst_ram #(
   parameter int DATA_BITWIDTH            = 64,
   parameter int DEPTH_BITWIDTH           = 8,
   parameter int BURST_COUNT              = 4,
   parameter int CYCLES_BEFORE_DATA_VALID = 6,
   parameter int CYCLES_BEFORE_INITIATED  = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd,
   input  logic                          cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]     addr,
   input  logic [DATA_BITWIDTH-1:0]      wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]    data_mask,
   output logic [DATA_BITWIDTH-1:0]      rd_data,
   output logic                          rd_data_valid,
   output logic                          busy
);

   localparam int BYTES   = DATA_BITWIDTH / 8;
   localparam int DEPTH   = 2 ** DEPTH_BITWIDTH;
   localparam int CNT_MAX = (CYCLES_BEFORE_INITIATED > CYCLES_BEFORE_DATA_VALID) ?
                            CYCLES_BEFORE_INITIATED : CYCLES_BEFORE_DATA_VALID;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BEAT_W  = $clog2(BURST_COUNT + 1);

   typedef enum logic [2:0] {
      INITIATE,
      IDLE,
      READ_DELAY,
      READ_BURST,
      WRITE_BURST
   } state_t;

   state_t                     state, state_nxt;
   logic [CNT_W-1:0]           cnt, cnt_nxt;
   logic [BEAT_W-1:0]          beat, beat_nxt;
   logic [DEPTH_BITWIDTH-1:0]  ptr, ptr_nxt;
   logic                       busy_nxt;
   logic                       vld_nxt;

   logic                       mem_we;
   logic [DEPTH_BITWIDTH-1:0]  mem_waddr;
   logic                       mem_re;
   logic [DEPTH_BITWIDTH-1:0]  mem_raddr;

   logic [DATA_BITWIDTH-1:0]   mem [DEPTH];

   // Control registers: state, counters, burst pointer and the two status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= INITIATE;
         cnt           <= '0;
         beat          <= '0;
         ptr           <= '0;
         busy          <= 1'b1;
         rd_data_valid <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         beat          <= beat_nxt;
         ptr           <= ptr_nxt;
         busy          <= busy_nxt;
         rd_data_valid <= vld_nxt;
      end
   end

   // Next-state logic; busy/valid are computed one cycle ahead so they leave
   // the block registered, and memory port controls are decoded here.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      beat_nxt  = beat;
      ptr_nxt   = ptr;
      busy_nxt  = busy;
      vld_nxt   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = ptr;
      mem_re    = 1'b0;
      mem_raddr = ptr;

      unique case (state)
         INITIATE: begin
            busy_nxt = 1'b1;
            if (cnt == CNT_W'(CYCLES_BEFORE_INITIATED)) begin
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         IDLE: begin
            busy_nxt = 1'b0;
            if (cmd_en) begin
               busy_nxt = 1'b1;
               cnt_nxt  = '0;
               if (cmd) begin
                  // Beat 0 goes straight to memory in the command cycle.
                  mem_we    = 1'b1;
                  mem_waddr = addr;
                  ptr_nxt   = addr + 1'b1;
                  beat_nxt  = BEAT_W'(1);
                  state_nxt = WRITE_BURST;
               end else begin
                  ptr_nxt   = addr;
                  state_nxt = READ_DELAY;
               end
            end
         end

         READ_DELAY: begin
            busy_nxt = 1'b1;
            // Issue the first read one cycle early to cover the registered read port.
            if (cnt == CNT_W'(CYCLES_BEFORE_DATA_VALID - 2)) begin
               mem_re    = 1'b1;
               mem_raddr = ptr;
               vld_nxt   = 1'b1;
               ptr_nxt   = ptr + 1'b1;
               beat_nxt  = BEAT_W'(1);
               state_nxt = READ_BURST;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         READ_BURST: begin
            busy_nxt = 1'b1;
            if (beat == BEAT_W'(BURST_COUNT)) begin
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               mem_re    = 1'b1;
               mem_raddr = ptr;
               vld_nxt   = 1'b1;
               ptr_nxt   = ptr + 1'b1;
               beat_nxt  = beat + 1'b1;
            end
         end

         WRITE_BURST: begin
            busy_nxt  = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = ptr;
            ptr_nxt   = ptr + 1'b1;
            beat_nxt  = beat + 1'b1;
            if (beat == BEAT_W'(BURST_COUNT - 1)) begin
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end

         default: begin
            busy_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = INITIATE;
         end
      endcase
   end

   // Byte-masked write port; a reset cycle suppresses the write so an aborted
   // burst never lands a beat after reset is seen.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int b = 0; b < BYTES; b++) begin
            if (!data_mask[b]) begin
               mem[mem_waddr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Registered read port; holds the last beat between bursts.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (mem_re) begin
         rd_data <= mem[mem_raddr];
      end
   end

endmodule

// File: tb/tb_burst_ram.sv
// Scoreboard bench for burst_ram: stimulus pushes expected read beats into a
// queue, a negedge monitor pops and compares every valid beat.
module tb_burst_ram;

   logic        clk;
   logic        rst;
   logic        cmd;
   logic        cmd_en;
   logic [7:0]  addr;
   logic [63:0] wr_data;
   logic [7:0]  data_mask;
   logic [63:0] rd_data;
   logic        rd_data_valid;
   logic        busy;

   int tests;
   int fails;
   logic [63:0] exp_q[$];

   burst_ram dut (
      .clk           (clk),
      .rst           (rst),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every valid beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (rd_data_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got %h with valid=1, required no beat", rd_data);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               fails++;
               $display("FAIL rd_beat: got %h required %h", rd_data, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      if (busy !== 1'b0) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: got busy=%b required 0 within 200 cycles", busy);
      end
   endtask

   task automatic wr_burst(input logic [7:0] a,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3,
                           input logic [7:0] m0, input logic [7:0] m1,
                           input logic [7:0] m2, input logic [7:0] m3);
      logic [63:0] d [4];
      logic [7:0]  m [4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
      wait_idle();
      cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = d[0]; data_mask = m[0];
      for (int i = 1; i < 4; i++) begin
         tick();
         cmd_en = 1'b0; addr = 8'h00;
         wr_data = d[i]; data_mask = m[i];
         check("wr_busy_during", {63'd0, busy}, 64'd1);
      end
      tick();
      wr_data = 64'h0; data_mask = 8'h00; cmd = 1'b0;
      check("wr_busy_release", {63'd0, busy}, 64'd0);
   endtask

   // Read burst at a; inject drives a write command at 0x40 two cycles after
   // the read command, which must be dropped.
   task automatic rd_burst(input logic [7:0] a,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3,
                           input bit inject);
      wait_idle();
      cmd = 1'b0; cmd_en = 1'b1; addr = a;
      exp_q.push_back(e0); exp_q.push_back(e1);
      exp_q.push_back(e2); exp_q.push_back(e3);
      tick();
      cmd_en = 1'b0; addr = 8'h00;
      for (int k = 1; k <= 10; k++) begin
         if (inject && k == 2) begin
            cmd = 1'b1; cmd_en = 1'b1; addr = 8'h40;
            wr_data = 64'hBADBADBADBADBAD0; data_mask = 8'h00;
         end
         if (inject && k == 3) begin
            cmd = 1'b0; cmd_en = 1'b0; addr = 8'h00; wr_data = 64'h0;
         end
         if (k == 5)  check("rd_valid_before_latency", {63'd0, rd_data_valid}, 64'd0);
         if (k == 6)  check("rd_valid_at_latency", {63'd0, rd_data_valid}, 64'd1);
         if (k == 9)  check("rd_busy_last_beat", {63'd0, busy}, 64'd1);
         if (k == 10) begin
            check("rd_busy_release", {63'd0, busy}, 64'd0);
            check("rd_valid_after_burst", {63'd0, rd_data_valid}, 64'd0);
            check("rd_data_hold", rd_data, e3);
         end
         if (k < 10) tick();
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = 8'h00;
      wr_data = 64'h0; data_mask = 8'h00;
      repeat (3) tick();
      check("reset_busy", {63'd0, busy}, 64'd1);
      check("reset_valid", {63'd0, rd_data_valid}, 64'd0);
      check("reset_rd_data", rd_data, 64'd0);

      // Init period; a read command at cycle 5 must be ignored.
      rst = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         cmd_en = (c == 5);
         check("init_busy", {63'd0, busy}, 64'd1);
      end
      tick();
      check("init_busy_release", {63'd0, busy}, 64'd0);

      // Write then read.
      wr_burst(8'h10, 64'h1111111111111111, 64'h2222222222222222,
               64'h3333333333333333, 64'h4444444444444444, 8'h00, 8'h00, 8'h00, 8'h00);
      rd_burst(8'h10, 64'h1111111111111111, 64'h2222222222222222,
               64'h3333333333333333, 64'h4444444444444444, 1'b0);

      // Byte mask merge and full mask.
      wr_burst(8'h20, 64'hAAAAAAAAAAAAAAAA, 64'h0123456789ABCDEF,
               64'hFEDCBA9876543210, 64'hDEADBEEFCAFEF00D, 8'h00, 8'h00, 8'h00, 8'h00);
      wr_burst(8'h20, 64'h5555555555555555, 64'h9999999999999999,
               64'h8888888888888888, 64'h7777777777777777, 8'h0F, 8'hFF, 8'hFF, 8'hFF);
      rd_burst(8'h20, 64'h55555555AAAAAAAA, 64'h0123456789ABCDEF,
               64'hFEDCBA9876543210, 64'hDEADBEEFCAFEF00D, 1'b0);

      // Address wrap.
      wr_burst(8'h02, 64'hC0C0C0C0C0C0C0C0, 64'hC1C1C1C1C1C1C1C1,
               64'hC2C2C2C2C2C2C2C2, 64'hC3C3C3C3C3C3C3C3, 8'h00, 8'h00, 8'h00, 8'h00);
      wr_burst(8'hFE, 64'hF0000000000000F0, 64'hF1000000000000F1,
               64'hF2000000000000F2, 64'hF3000000000000F3, 8'h00, 8'h00, 8'h00, 8'h00);
      rd_burst(8'h00, 64'hF2000000000000F2, 64'hF3000000000000F3,
               64'hC0C0C0C0C0C0C0C0, 64'hC1C1C1C1C1C1C1C1, 1'b0);
      rd_burst(8'hFE, 64'hF0000000000000F0, 64'hF1000000000000F1,
               64'hF2000000000000F2, 64'hF3000000000000F3, 1'b0);

      // Command dropped while busy.
      wr_burst(8'h40, 64'hE0E0E0E0E0E0E0E0, 64'hE1E1E1E1E1E1E1E1,
               64'hE2E2E2E2E2E2E2E2, 64'hE3E3E3E3E3E3E3E3, 8'h00, 8'h00, 8'h00, 8'h00);
      rd_burst(8'h10, 64'h1111111111111111, 64'h2222222222222222,
               64'h3333333333333333, 64'h4444444444444444, 1'b1);
      rd_burst(8'h40, 64'hE0E0E0E0E0E0E0E0, 64'hE1E1E1E1E1E1E1E1,
               64'hE2E2E2E2E2E2E2E2, 64'hE3E3E3E3E3E3E3E3, 1'b0);

      // Reset at the second valid beat of a read.
      wait_idle();
      cmd = 1'b0; cmd_en = 1'b1; addr = 8'h10;
      exp_q.push_back(64'h1111111111111111);
      exp_q.push_back(64'h2222222222222222);
      tick();
      cmd_en = 1'b0; addr = 8'h00;
      repeat (6) tick();
      check("mid_read_second_beat", {63'd0, rd_data_valid}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_read_valid_drop", {63'd0, rd_data_valid}, 64'd0);
      check("mid_read_busy", {63'd0, busy}, 64'd1);
      check("mid_read_rd_data_clr", rd_data, 64'd0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 5) begin
            cmd = 1'b1; cmd_en = 1'b1; addr = 8'h10;
            wr_data = 64'hDEADDEADDEADDEAD; data_mask = 8'h00;
         end else begin
            cmd = 1'b0; cmd_en = 1'b0; addr = 8'h00; wr_data = 64'h0;
         end
         check("reinit_busy", {63'd0, busy}, 64'd1);
      end
      tick();
      check("reinit_busy_release", {63'd0, busy}, 64'd0);
      rd_burst(8'h10, 64'h1111111111111111, 64'h2222222222222222,
               64'h3333333333333333, 64'h4444444444444444, 1'b0);

      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
